// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU data bus between the cpu initiator and data_mem_responder
interface data_mem_responder_if;
  logic [31:0] ADDR;
  logic [31:0] DATA_BUS_WRITE;
  logic        cs;
  logic        we;
  logic [31:0] DATA_BUS_READ;

  modport master (
    output ADDR,
    output DATA_BUS_WRITE,
    output cs,
    output we,
    input  DATA_BUS_READ
  );

  modport slave (
    input  ADDR,
    input  DATA_BUS_WRITE,
    input  cs,
    input  we,
    output DATA_BUS_READ
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM plus small MMIO register bank serving the CPU data bus
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2       = 10,
  parameter logic [15:0] MMIO_BASE        = 16'hFFFF,
  parameter logic [31:0] UNMAPPED_PATTERN = 32'hDEDE_AFAF
) (
  input  logic                  clkIn,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  output logic [31:0]           gpio_out,
  output logic                  bus_err
);

  localparam int unsigned RAM_WORDS = 1 << DEPTH_LOG2;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] rdata_q;
  logic [31:0] scratch_q;
  logic [31:0] cycle_cnt_q;
  logic [31:0] wr_count_q;

  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  unmapped;
  logic [1:0]            reg_sel;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [31:0]           read_word;
  logic                  unused_byte_bits;

  // Byte lane bits are don't-care: every access is a whole word.
  assign unused_byte_bits = &bus.ADDR[1:0];

  always_comb begin
    ram_hit  = (bus.ADDR[31:DEPTH_LOG2+2] == '0);
    mmio_hit = !ram_hit && (bus.ADDR[31:16] == MMIO_BASE) && (bus.ADDR[15:2] < 14'd4);
    unmapped = !ram_hit && !mmio_hit;
    reg_sel  = bus.ADDR[3:2];
    ram_idx  = bus.ADDR[DEPTH_LOG2+1:2];
  end

  always_comb begin
    read_word = UNMAPPED_PATTERN;
    if (ram_hit) begin
      read_word = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        2'd0:    read_word = gpio_out;
        2'd1:    read_word = cycle_cnt_q;
        2'd2:    read_word = wr_count_q;
        default: read_word = scratch_q;
      endcase
    end
  end

  // RAM is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clkIn) begin
    if (rst && bus.cs && bus.we && ram_hit) begin
      ram[ram_idx] <= bus.DATA_BUS_WRITE;
    end
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      rdata_q     <= '0;
      gpio_out    <= '0;
      bus_err     <= 1'b0;
      cycle_cnt_q <= '0;
      wr_count_q  <= '0;
      scratch_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (bus.cs) begin
        if (unmapped) begin
          bus_err <= 1'b1;
        end
        if (bus.we) begin
          if (ram_hit && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_q <= wr_count_q + 32'd1;
          end
          if (mmio_hit && (reg_sel == 2'd0)) begin
            gpio_out <= bus.DATA_BUS_WRITE;
          end
          if (mmio_hit && (reg_sel == 2'd3)) begin
            scratch_q <= bus.DATA_BUS_WRITE;
          end
        end else begin
          rdata_q <= read_word;
        end
      end
    end
  end

  assign bus.DATA_BUS_READ = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_out;
  logic        bus_err;

  data_mem_responder_if bus ();

  data_mem_responder dut (
    .clkIn    (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .gpio_out (gpio_out),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_gpio;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic cs, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd,
                     input logic [31:0] gpio, input logic err);
    vec_t v;
    v.cs = cs; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rd = rd; v.exp_gpio = gpio; v.exp_err = err;
    vq.push_back(v);
  endtask

  // Called at a negedge: drive, take one rising edge, check, return at next negedge.
  task automatic step(input string name, input logic cs, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rd, input logic [31:0] gpio, input logic err);
    bus.cs = cs; bus.we = we; bus.ADDR = addr; bus.DATA_BUS_WRITE = wdata;
    @(posedge clk);
    #1;
    chk({name, ".rd"}, bus.DATA_BUS_READ, rd);
    chk({name, ".gpio"}, gpio_out, gpio);
    chk({name, ".err"}, {31'd0, bus_err}, {31'd0, err});
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.ADDR = '0; bus.DATA_BUS_WRITE = '0;

    // Vector i lands on rising edge i+1 after release, so CYCLE_CNT reads back i.
    for (int i = 0; i < 4; i++) add(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    add(1, 0, 32'hFFFF_0004, 32'h0,         32'h0000_0004, 32'h0,  0);
    add(1, 1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0004, 32'h0,  0);
    add(1, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 32'h0,  0);
    add(1, 0, 32'h0000_0013, 32'h0,         32'h1234_5678, 32'h0,  0);
    add(1, 0, 32'hFFFF_0008, 32'h0,         32'h0000_0001, 32'h0,  0);
    add(1, 1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0000_0001, 32'h0,  0);
    add(1, 0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 32'h0,  0);
    add(1, 0, 32'hFFFF_0008, 32'h0,         32'h0000_0002, 32'h0,  0);
    add(1, 1, 32'hFFFF_0000, 32'h0000_00FF, 32'h0000_0002, 32'hFF, 0);
    add(1, 1, 32'hFFFF_0004, 32'h0000_1234, 32'h0000_0002, 32'hFF, 0);
    add(1, 0, 32'hFFFF_0004, 32'h0,         32'h0000_000E, 32'hFF, 0);
    add(1, 1, 32'hFFFF_000C, 32'hCAFE_F00D, 32'h0000_000E, 32'hFF, 0);
    add(1, 0, 32'hFFFF_000C, 32'h0,         32'hCAFE_F00D, 32'hFF, 0);
    add(1, 0, 32'hFFFF_0000, 32'h0,         32'h0000_00FF, 32'hFF, 0);
    add(1, 1, 32'h0000_0040, 32'h1111_1111, 32'h0000_00FF, 32'hFF, 0);
    add(1, 0, 32'h0000_0040, 32'h0,         32'h1111_1111, 32'hFF, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 32'h0, 32'h1111_1111, 32'hFF, 0);
    add(1, 1, 32'h0000_0044, 32'h2222_2222, 32'h1111_1111, 32'hFF, 0);
    add(1, 0, 32'h0000_1000, 32'h0,         32'hDEDE_AFAF, 32'hFF, 1);
    add(1, 1, 32'hFFFF_0010, 32'h5555_5555, 32'hDEDE_AFAF, 32'hFF, 1);
    add(1, 0, 32'h0000_0044, 32'h0,         32'h2222_2222, 32'hFF, 1);
    add(1, 1, 32'h0000_1040, 32'h9999_9999, 32'h2222_2222, 32'hFF, 1);
    add(1, 0, 32'h0000_0040, 32'h0,         32'h1111_1111, 32'hFF, 1);
    add(1, 0, 32'hFFFF_0008, 32'h0,         32'h0000_0004, 32'hFF, 1);
    add(1, 0, 32'hFFFF_0010, 32'h0,         32'hDEDE_AFAF, 32'hFF, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.rd", bus.DATA_BUS_READ, 32'h0);
    chk("reset.gpio", gpio_out, 32'h0);
    chk("reset.err", {31'd0, bus_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].cs, vq[i].we, vq[i].addr, vq[i].wdata,
           vq[i].exp_rd, vq[i].exp_gpio, vq[i].exp_err);
    end

    // Reset mid-run: asynchronous clear, cs ignored during reset, RAM preserved.
    step("mid.wr20", 1, 1, 32'h0000_0020, 32'h0000_BEEF, 32'hDEDE_AFAF, 32'hFF, 1);
    step("mid.rd40", 1, 0, 32'h0000_0040, 32'h0,         32'h1111_1111, 32'hFF, 1);
    bus.cs = 1'b1; bus.we = 1'b1; bus.ADDR = 32'hFFFF_0000; bus.DATA_BUS_WRITE = 32'h0000_ABCD;
    rst = 1'b0;
    #1;
    chk("async.rd", bus.DATA_BUS_READ, 32'h0);
    chk("async.gpio", gpio_out, 32'h0);
    chk("async.err", {31'd0, bus_err}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_cs_ignored.gpio", gpio_out, 32'h0);
    chk("rst_cs_ignored.rd", bus.DATA_BUS_READ, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step("post.cycle", 1, 0, 32'hFFFF_0004, 32'h0, 32'h0000_0000, 32'h0, 0);
    step("post.wrcnt", 1, 0, 32'hFFFF_0008, 32'h0, 32'h0000_0000, 32'h0, 0);
    step("post.scratch", 1, 0, 32'hFFFF_000C, 32'h0, 32'h0000_0000, 32'h0, 0);
    step("post.ram20", 1, 0, 32'h0000_0020, 32'h0, 32'h0000_BEEF, 32'h0, 0);
    step("post.ram44", 1, 0, 32'h0000_0044, 32'h0, 32'h2222_2222, 32'h0, 0);
    step("post.gpio", 1, 0, 32'hFFFF_0000, 32'h0, 32'h0000_0000, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
